sfq_ndo_driver: RTL and testbench

- Clocked sequencer that acts as initiator for a non-destructive-readout (NDO) storage cell.
- Accepts set/clear/read commands over a valid/ready handshake.
- Drives the cell's set, reset and clk inputs as single toggle events; each transition, rising or falling, is one pulse.
- Captures the cell's out and resout toggles, returns read/clear results, and checks them against a shadow copy of the cell state.
- Sits between the digital test controller and the NDO cell model in cell-characterisation benches.

---
 rtl/sfq_ndo_driver.sv | 214 +++++++++++++++++++++
 tb/tb_sfq_ndo_driver.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfq_ndo_driver.sv
// sfq_ndo_driver
// Initiator/sequencer for a non-destructive-readout (NDO) storage cell.
// Commands (SET/CLEAR/READ) are accepted over a valid/ready handshake. Each
// command is issued as a single toggle on ndo_set/ndo_reset/ndo_clk. Toggles
// returned on ndo_out/ndo_resout are captured during a response window and
// judged against a shadow copy of the cell state.
//
// Ports:
//   clk, reset           sequencer clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_op[1:0]          01=SET, 10=CLEAR, 11=READ, 00=reserved
//   rsp_valid/rsp_ready  response handshake (valid held until ready)
//   rsp_data             READ: out toggle seen; CLEAR: resout toggle seen
//   rsp_err              inconsistent response or protocol error
//   err_sticky           latched on any unexpected cell toggle
//   ndo_set/reset/clk    toggle-encoded drives into the cell
//   ndo_out/ndo_resout   toggle-encoded, asynchronous cell outputs
module sfq_ndo_driver #(
    parameter int WINDOW = 8,
    parameter int GUARD  = 4,
    parameter int CNTW   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_data,
    output logic       rsp_err,
    output logic       err_sticky,
    output logic       ndo_set,
    output logic       ndo_reset,
    output logic       ndo_clk,
    input  logic       ndo_out,
    input  logic       ndo_resout
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GUARD, S_RESP} state_t;
    typedef enum logic [1:0] {
        OP_RSVD  = 2'b00,
        OP_SET   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    state_t          r_state, w_state_nxt;
    op_t             r_op, w_op_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]      r_hits, w_hits_nxt;    // expected detections, saturates at 2
    logic            r_flag, w_flag_nxt;    // unexpected/guard detection seen
    logic            r_shadow, w_shadow_nxt;
    logic            r_rsp_data, w_rsp_data_nxt;
    logic            r_rsp_err, w_rsp_err_nxt;
    logic            r_sticky, w_sticky_nxt;
    logic            r_set, w_set_nxt;
    logic            r_rst, w_rst_nxt;
    logic            r_clk, w_clk_nxt;
    logic            r_cmd_ready, r_rsp_valid;
    logic [2:0]      r_out_sync, r_res_sync;
    logic [1:0]      r_mask;

    logic w_armed, w_det_out, w_det_res, w_det_any;
    logic w_exp_det, w_oth_det;
    logic w_checked, w_any, w_mismatch, w_spurious;

    // [1] is the synchronized level, [2] its previous value; any difference is one pulse.
    // Detections stay masked until three clean cycles follow reset release.
    assign w_armed   = (r_mask == 2'd3);
    assign w_det_out = (r_out_sync[1] ^ r_out_sync[2]) & w_armed;
    assign w_det_res = (r_res_sync[1] ^ r_res_sync[2]) & w_armed;
    assign w_det_any = w_det_out | w_det_res;

    always_comb begin
        w_exp_det = 1'b0;
        w_oth_det = w_det_any;
        case (r_op)
            OP_CLEAR: begin w_exp_det = w_det_res; w_oth_det = w_det_out; end
            OP_READ:  begin w_exp_det = w_det_out; w_oth_det = w_det_res; end
            default:  ;
        endcase
    end

    // Only READ and CLEAR have an expected response to compare with the shadow.
    assign w_checked  = (r_op == OP_READ) || (r_op == OP_CLEAR);
    assign w_any      = (r_hits != 2'd0);
    assign w_mismatch = w_checked && (w_any != r_shadow);
    assign w_spurious = w_checked && w_any && !r_shadow;

    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_cnt_nxt      = r_cnt;
        w_hits_nxt     = r_hits;
        w_flag_nxt     = r_flag;
        w_shadow_nxt   = r_shadow;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_err_nxt  = r_rsp_err;
        w_sticky_nxt   = r_sticky;
        w_set_nxt      = r_set;
        w_rst_nxt      = r_rst;
        w_clk_nxt      = r_clk;
        case (r_state)
            S_IDLE: begin
                if (w_det_any) w_sticky_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_op_nxt   = op_t'(cmd_op);
                    w_hits_nxt = 2'd0;
                    w_flag_nxt = 1'b0;
                    if (op_t'(cmd_op) == OP_RSVD) begin
                        w_rsp_data_nxt = 1'b0;
                        w_rsp_err_nxt  = 1'b1;
                        w_state_nxt    = S_RESP;
                    end else begin
                        case (op_t'(cmd_op))
                            OP_SET:   w_set_nxt = ~r_set;
                            OP_CLEAR: w_rst_nxt = ~r_rst;
                            default:  w_clk_nxt = ~r_clk;
                        endcase
                        w_cnt_nxt   = CNTW'(WINDOW - 1);
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_exp_det && !r_hits[1]) w_hits_nxt = r_hits + 2'd1;
                if (w_oth_det) begin
                    w_flag_nxt   = 1'b1;
                    w_sticky_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_cnt_nxt   = CNTW'(GUARD - 1);
                    w_state_nxt = S_GUARD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_GUARD: begin
                if (w_det_any) begin
                    w_flag_nxt   = 1'b1;
                    w_sticky_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    // A detection on this final guard edge is folded in directly.
                    w_rsp_data_nxt = (r_hits == 2'd1);
                    w_rsp_err_nxt  = r_flag | w_det_any | r_hits[1] | w_mismatch;
                    if (r_hits[1] || w_spurious) w_sticky_nxt = 1'b1;
                    if (r_op == OP_SET)   w_shadow_nxt = 1'b1;
                    if (r_op == OP_CLEAR) w_shadow_nxt = 1'b0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_RESP: begin
                if (w_det_any) w_sticky_nxt = 1'b1;
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_RSVD;
            r_cnt       <= '0;
            r_hits      <= '0;
            r_flag      <= 1'b0;
            r_shadow    <= 1'b0;
            r_rsp_data  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_sticky    <= 1'b0;
            r_set       <= 1'b0;
            r_rst       <= 1'b0;
            r_clk       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_out_sync  <= '0;
            r_res_sync  <= '0;
            r_mask      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hits      <= w_hits_nxt;
            r_flag      <= w_flag_nxt;
            r_shadow    <= w_shadow_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_sticky    <= w_sticky_nxt;
            r_set       <= w_set_nxt;
            r_rst       <= w_rst_nxt;
            r_clk       <= w_clk_nxt;
            // Registered handshake flags keep every output low during reset.
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_out_sync  <= {r_out_sync[1:0], ndo_out};
            r_res_sync  <= {r_res_sync[1:0], ndo_resout};
            if (r_mask != 2'd3) r_mask <= r_mask + 2'd1;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign err_sticky = r_sticky;
    assign ndo_set    = r_set;
    assign ndo_reset  = r_rst;
    assign ndo_clk    = r_clk;

endmodule

// File: tb/tb_sfq_ndo_driver.sv
// Testbench for sfq_ndo_driver: directed scenarios plus randomized commands
// with randomized cell toggles, judged by a window-classification model.
module tb_sfq_ndo_driver;

    localparam int WINDOW = 8;
    localparam int GUARD  = 4;
    localparam logic [1:0] OP_RSVD = 2'b00, OP_SET = 2'b01, OP_CLEAR = 2'b10, OP_READ = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_data, rsp_err, err_sticky;
    logic       ndo_set, ndo_reset, ndo_clk;
    logic       ndo_out = 1'b0;
    logic       ndo_resout = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the cell-facing state as seen by the controller.
    logic m_shadow = 1'b0, m_sticky = 1'b0;
    logic m_set = 1'b0, m_rst = 1'b0, m_clk = 1'b0;

    sfq_ndo_driver #(.WINDOW(WINDOW), .GUARD(GUARD), .CNTW(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .err_sticky(err_sticky),
        .ndo_set(ndo_set), .ndo_reset(ndo_reset), .ndo_clk(ndo_clk),
        .ndo_out(ndo_out), .ndo_resout(ndo_resout)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_shadow = 1'b0; m_sticky = 1'b0; m_set = 1'b0; m_rst = 1'b0; m_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One command with ndo_out/ndo_resout toggled after acceptance-relative edges
    // given by the bit masks (bit k = toggle just after edge k, k in 1..13).
    // A toggle after edge k reaches the detector on edge k+3.
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] mout, input logic [15:0] mres,
                          output logic o_data, output logic o_err);
        int   hits;
        logic oth, grd, late, ein, oin, chk, any, e_data, e_err;
        hits = 0; oth = 0; grd = 0; late = 0;
        for (int k = 1; k <= 13; k++) begin
            ein = (op == OP_CLEAR) ? mres[k] : (op == OP_READ) ? mout[k] : 1'b0;
            oin = (op == OP_CLEAR) ? mout[k] : (op == OP_READ) ? mres[k] : (mout[k] | mres[k]);
            if (k + 3 <= WINDOW) begin
                if (ein) hits++;
                if (oin) oth = 1'b1;
            end else if (k + 3 <= WINDOW + GUARD) begin
                if (mout[k] | mres[k]) grd = 1'b1;
            end else if (mout[k] | mres[k]) begin
                late = 1'b1;
            end
        end
        chk    = (op == OP_READ) || (op == OP_CLEAR);
        any    = (hits > 0);
        e_data = (hits == 1);
        e_err  = (hits >= 2) || oth || grd || (chk && (any != m_shadow));
        if (oth || grd || late || hits >= 2 || (chk && any && !m_shadow)) m_sticky = 1'b1;

        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = 2'b00;
        if (op == OP_SET)   m_set = ~m_set;
        if (op == OP_CLEAR) m_rst = ~m_rst;
        if (op == OP_READ)  m_clk = ~m_clk;
        n_checks++;
        if ({ndo_set, ndo_reset, ndo_clk} !== {m_set, m_rst, m_clk}) begin
            n_fail++;
            $display("FAIL pulse_op%0d: got set/rst/clk=%b%b%b expected %b%b%b",
                     op, ndo_set, ndo_reset, ndo_clk, m_set, m_rst, m_clk);
        end
        o_data = 1'bx; o_err = 1'bx;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== (k >= WINDOW + GUARD)) begin
                n_fail++;
                $display("FAIL rsp_valid_timing k=%0d: got %b expected %b", k, rsp_valid, (k >= WINDOW + GUARD));
            end
            if (k == WINDOW + GUARD) begin
                o_data = rsp_data; o_err = rsp_err;
                n_checks++;
                if ({rsp_data, rsp_err} !== {e_data, e_err}) begin
                    n_fail++;
                    $display("FAIL rsp_op%0d: got data/err=%b%b expected %b%b", op, rsp_data, rsp_err, e_data, e_err);
                end
            end
            if (k <= 13) begin
                if (mout[k]) ndo_out = ~ndo_out;
                if (mres[k]) ndo_resout = ~ndo_resout;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (op == OP_SET)   m_shadow = 1'b1;
        if (op == OP_CLEAR) m_shadow = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready, err_sticky} !== {1'b0, 1'b1, m_sticky}) begin
            n_fail++;
            $display("FAIL after_handshake: got valid/ready/sticky=%b%b%b expected 01%b",
                     rsp_valid, cmd_ready, err_sticky, m_sticky);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_err, err_sticky, ndo_set, ndo_reset, ndo_clk} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {cmd_ready, rsp_valid, rsp_data, rsp_err, err_sticky, ndo_set, ndo_reset, ndo_clk});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_set_read();
        logic d, e;
        do_cmd(OP_SET, 16'h0, 16'h0, d, e);
        n_checks++;
        if ({d, e, ndo_set} !== 3'b001) begin
            n_fail++; $display("FAIL set_basic: got data/err/set=%b%b%b expected 001", d, e, ndo_set);
        end
        do_cmd(OP_READ, 16'h0020, 16'h0, d, e);
        n_checks++;
        if ({d, e} !== 2'b10) begin
            n_fail++; $display("FAIL read_set1: got %b%b expected 10", d, e);
        end
        do_cmd(OP_READ, 16'h0020, 16'h0, d, e);
        n_checks++;
        if ({d, e, ndo_clk} !== 3'b100) begin
            n_fail++; $display("FAIL read_set2: got data/err/clk=%b%b%b expected 100", d, e, ndo_clk);
        end
    endtask

    task automatic test_clear();
        logic d, e;
        do_cmd(OP_CLEAR, 16'h0, 16'h0008, d, e);
        n_checks++;
        if ({d, e} !== 2'b10) begin
            n_fail++; $display("FAIL clear_hit: got %b%b expected 10", d, e);
        end
        do_cmd(OP_READ, 16'h0, 16'h0, d, e);
        n_checks++;
        if ({d, e} !== 2'b00) begin
            n_fail++; $display("FAIL read_cleared: got %b%b expected 00", d, e);
        end
    endtask

    task automatic test_read_unset();
        logic d, e;
        apply_reset();
        do_cmd(OP_READ, 16'h0020, 16'h0, d, e);
        n_checks++;
        if ({d, e, err_sticky} !== 3'b111) begin
            n_fail++; $display("FAIL read_unset: got data/err/sticky=%b%b%b expected 111", d, e, err_sticky);
        end
    endtask

    task automatic test_guard();
        logic d, e;
        apply_reset();
        do_cmd(OP_SET, 16'h0080, 16'h0, d, e);
        n_checks++;
        if ({e, err_sticky} !== 2'b11) begin
            n_fail++; $display("FAIL guard_toggle: got err/sticky=%b%b expected 11", e, err_sticky);
        end
    endtask

    task automatic test_idle_toggle();
        apply_reset();
        ndo_resout = ~ndo_resout;
        repeat (6) @(posedge clk);
        #1;
        m_sticky = 1'b1;
        n_checks++;
        if ({err_sticky, rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL idle_toggle: got sticky/valid=%b%b expected 10", err_sticky, rsp_valid);
        end
    endtask

    task automatic test_op00();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_RSVD;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_err, cmd_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL op00_resp: got valid/data/err/ready=%b%b%b%b expected 1010", rsp_valid, rsp_data, rsp_err, cmd_ready);
        end
        n_checks++;
        if ({ndo_set, ndo_reset, ndo_clk} !== {m_set, m_rst, m_clk}) begin
            n_fail++; $display("FAIL op00_nopulse: got %b%b%b expected %b%b%b",
                               ndo_set, ndo_reset, ndo_clk, m_set, m_rst, m_clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL op00_done: got valid/ready=%b%b expected 01", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_READ;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_err, err_sticky, ndo_set, ndo_reset, ndo_clk} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 00000000",
                     {cmd_ready, rsp_valid, rsp_data, rsp_err, err_sticky, ndo_set, ndo_reset, ndo_clk});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_shadow = 1'b0; m_sticky = 1'b0; m_set = 1'b0; m_rst = 1'b0; m_clk = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_ready: got %b expected 1", cmd_ready);
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_mid_norsp cyc=%0d: got %b expected 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [15:0] mo, mr;
        logic        d, e;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(1, 3));
            mo = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom) & 16'h3FFE;
            mr = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom) & 16'h3FFE;
            do_cmd(op, mo, mr, d, e);
        end
    endtask

    initial begin
        test_reset();
        test_set_read();
        test_clear();
        test_read_unset();
        test_guard();
        test_idle_toggle();
        test_op00();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
